pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage MIPS pipeline. Drives the enable and synchronous-clear inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB enable-and-reset pipeline registers. Handles load-use interlock, taken-branch flush, multi-cycle MDU (mult/div) occupancy and data-memory wait states. Sits beside the datapath; consumes decode/EX/MEM status and produces only control.

---
 rtl/pipe_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch flush, MDU occupancy, memory waits.
// Optional HAZARD_PERF_EN adds stall_cycles / flush_events performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned REGW    = 5,
    parameter int unsigned MDU_LAT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            ex_memread,
    input  logic [REGW-1:0] ex_rt,
    input  logic            ex_branch_taken,
    input  logic            ex_mdu_start,
    input  logic            mem_req,
    input  logic            mem_ready,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_en,
    output logic            exmem_en,
    output logic            memwb_en,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            exmem_flush,
    output logic            memwb_flush,
`ifdef HAZARD_PERF_EN
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_events,
`endif
    output logic            mdu_busy
);

    typedef enum logic [1:0] {RUN, MDU_BUSY, MDU_DONE} state_t;

    localparam logic [7:0] CNT_INIT = 8'(MDU_LAT - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       mem_stall;
    logic       load_use;
    logic       allow_bl;
    logic       branch_fire;

    assign mem_stall = mem_req & ~mem_ready;
    assign load_use  = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        mdu_busy    = 1'b0;
        allow_bl    = 1'b0;
        branch_fire = 1'b0;

        if (reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else begin
            mdu_busy = (state == MDU_BUSY);
            if (mem_stall) begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (ex_mdu_start) begin
                            pc_en       = 1'b0;
                            ifid_en     = 1'b0;
                            idex_en     = 1'b0;
                            exmem_flush = 1'b1;
                            state_nxt   = MDU_BUSY;
                            cnt_nxt     = CNT_INIT;
                        end else begin
                            allow_bl = 1'b1;
                        end
                    end
                    MDU_BUSY: begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_flush = 1'b1;
                        cnt_nxt     = cnt - 8'd1;
                        if (cnt == 8'd1)
                            state_nxt = MDU_DONE;
                    end
                    MDU_DONE: begin
                        // MDU op leaves EX on this edge, so its start level is no longer meaningful
                        allow_bl  = 1'b1;
                        state_nxt = RUN;
                    end
                    default: state_nxt = RUN;
                endcase

                if (allow_bl) begin
                    if (ex_branch_taken) begin
                        branch_fire = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_en)
                stall_cycles <= stall_cycles + 32'd1;
            if (branch_fire)
                flush_events <= flush_events + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver queues hand-computed control vectors, monitor compares each cycle.
module tb_pipe_hazard_ctrl;

    localparam int unsigned REGW = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic [REGW-1:0] id_rs, id_rt, ex_rt;
    logic            ex_memread, ex_branch_taken, ex_mdu_start, mem_req, mem_ready;
    logic            pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic            ifid_flush, idex_flush, exmem_flush, memwb_flush, mdu_busy;
`ifdef HAZARD_PERF_EN
    logic [31:0]     stall_cycles, flush_events;
`endif

    pipe_hazard_ctrl #(.REGW(REGW), .MDU_LAT(4)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .ex_mdu_start(ex_mdu_start), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
`ifdef HAZARD_PERF_EN
        .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
        .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    // {pc,ifid,idex,exmem,memwb}_en, {ifid,idex,exmem,memwb}_flush, mdu_busy
    localparam logic [9:0] RST  = 10'b00000_1111_0;
    localparam logic [9:0] DEF  = 10'b11111_0000_0;
    localparam logic [9:0] LU   = 10'b00111_0100_0;
    localparam logic [9:0] BR   = 10'b11111_1100_0;
    localparam logic [9:0] MST  = 10'b00011_0010_0;
    localparam logic [9:0] MBSY = 10'b00011_0010_1;
    localparam logic [9:0] MEMS = 10'b00000_0000_0;
    localparam logic [9:0] MEMB = 10'b00000_0000_1;

    typedef struct {
        logic [9:0] exp;
        string      name;
    } exp_t;

    exp_t queue_exp[$];
    int   checks = 0;
    int   passed = 0;

    task automatic step(input logic rst, input logic [REGW-1:0] rs, input logic [REGW-1:0] rt,
                        input logic mrd, input logic [REGW-1:0] xrt, input logic br,
                        input logic mdu, input logic req, input logic rdy,
                        input logic [9:0] exp, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; id_rs = rs; id_rt = rt; ex_memread = mrd; ex_rt = xrt;
        ex_branch_taken = br; ex_mdu_start = mdu; mem_req = req; mem_ready = rdy;
        e.exp = exp;
        e.name = name;
        queue_exp.push_back(e);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [9:0] act;
        forever begin
            @(negedge clk);
            if (queue_exp.size() != 0) begin
                e = queue_exp.pop_front();
                act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                       ifid_flush, idex_flush, exmem_flush, memwb_flush, mdu_busy};
                checks++;
                if (act === e.exp)
                    passed++;
                else
                    $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
            end
        end
    end

    initial begin : driver
        reset = 1'b1; id_rs = '0; id_rt = '0; ex_memread = 1'b0; ex_rt = '0;
        ex_branch_taken = 1'b0; ex_mdu_start = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 0, 0, 0, 0, 0, RST, "reset_hold");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, "after_reset");

        step(0, 8, 1, 1, 8, 0, 0, 0, 0, LU,  "loaduse_rs");
        step(0, 8, 1, 0, 8, 0, 0, 0, 0, DEF, "loaduse_after");
        step(0, 3, 9, 1, 9, 0, 0, 0, 0, LU,  "loaduse_rt");
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, DEF, "loaduse_r0");
        step(0, 7, 6, 1, 8, 0, 0, 0, 0, DEF, "loaduse_nomatch");

        step(0, 8, 1, 1, 8, 1, 0, 0, 0, BR,  "branch_over_lu");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, "branch_after");

        step(0, 0, 0, 0, 0, 0, 1, 0, 0, MST,  "mdu_start");
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, MBSY, "mdu_busy1");
        step(0, 0, 0, 0, 0, 1, 1, 0, 0, MBSY, "mdu_busy_br_ign");
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, MBSY, "mdu_busy3");
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, DEF,  "mdu_done");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,  "mdu_run");

        step(0, 0, 0, 0, 0, 0, 1, 0, 0, MST,  "mdu2_start");
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, MBSY, "mdu2_busy_c3");
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 0, 0, 1, 1, 0, MEMB, "mdu2_memstall");
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, MBSY, "mdu2_busy_c2");
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, MBSY, "mdu2_busy_c1");
        step(0, 0, 0, 0, 0, 1, 1, 0, 0, BR,   "mdu2_done_br");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,  "mdu2_run");

        step(0, 0, 0, 0, 0, 0, 1, 0, 0, MST,  "mdu3_start");
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, MBSY, "mdu3_busy");
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, RST,  "mdu3_reset");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,  "mdu3_rel1");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,  "mdu3_rel2");
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, MST,  "mdu4_start");
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, MBSY, "mdu4_busy_nolvl");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF,  "mdu4_done");

        step(0, 0, 0, 0, 0, 0, 0, 1, 0, MEMS, "memstall_run");
        step(0, 8, 0, 1, 8, 1, 0, 1, 0, MEMS, "memstall_over_br");
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, DEF,  "mem_ready");

        repeat (2) @(posedge clk);
        if (queue_exp.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending expected 0", queue_exp.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
